tflite_img_reader: RTL and testbench

TFLITE_IMG_READER -- requirements
Module: tflite_img_reader

---
 rtl/tflite_img_reader.sv | 143 ++++++++++++++
 tb/tb_tflite_img_reader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tflite_img_reader.sv
// tflite_img_reader: streams word_cnt words from the image buffer, starting at base_addr, to the NPU.
// It uses buffer reads with credit-based flow control and a small output FIFO.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   start/base_addr/word_cnt/busy/done   transfer control
//   buf_adb/buf_ceb/buf_oce/buf_dout     image buffer read port
//   m_data/m_valid/m_ready/m_last        valid/ready word stream
// Optional macro TFLITE_IMG_READER_BYTESWAP_EN byte-reverses each word.
module tflite_img_reader #(
  parameter int ADDR_W     = 12,
  parameter int CNT_W      = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] buf_adb,
  output logic              buf_ceb,
  output logic              buf_oce,
  input  logic [31:0]       buf_dout,
  output logic [31:0]       m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;

  typedef enum logic [1:0] {
    IDLE, READ, DRAIN, DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  rd_rem;
  logic [CNT_W-1:0]  pop_rem;
  logic              rd_pend;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [OW-1:0]     count;
  logic [OW:0]       need;
  logic              push;
  logic              pop;
  logic              can_issue;
  logic [31:0]       head;
  logic [31:0]       head_fmt;

  assign buf_oce = 1'b1;
  assign push    = rd_pend;
  assign m_valid = (count != '0);
  assign pop     = m_valid & m_ready;

  // Entries already owned: stored words, the word landing this edge,
  // and the read issued last cycle. A new read needs one free slot.
  assign need = (OW+1)'(count) + (OW+1)'(rd_pend)
              + (OW+1)'(buf_ceb) - (OW+1)'(pop);
  assign can_issue = need < (OW+1)'(FIFO_DEPTH);

  assign head = mem[rd_ptr];
`ifdef TFLITE_IMG_READER_BYTESWAP_EN
  assign head_fmt = {head[7:0], head[15:8], head[23:16], head[31:24]};
`else
  assign head_fmt = head;
`endif
  assign m_data = m_valid ? head_fmt : '0;
  assign m_last = m_valid && (pop_rem == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= buf_dout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + OW'(push) - OW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      buf_ceb <= 1'b0;
      buf_adb <= '0;
      rd_rem  <= '0;
      pop_rem <= '0;
      rd_pend <= 1'b0;
    end else begin
      // buffer data is valid the cycle after an enabled read
      rd_pend <= buf_ceb;
      buf_ceb <= 1'b0;
      done    <= 1'b0;
      if (pop) pop_rem <= pop_rem - 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            pop_rem <= word_cnt;
            if (word_cnt == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              buf_ceb <= 1'b1;
              buf_adb <= base_addr;
              rd_rem  <= word_cnt - 1'b1;
              state   <= (word_cnt == CNT_W'(1)) ? DRAIN : READ;
            end
          end
        end
        READ: begin
          if (can_issue) begin
            buf_ceb <= 1'b1;
            buf_adb <= buf_adb + 1'b1;
            rd_rem  <= rd_rem - 1'b1;
            if (rd_rem == CNT_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && pop_rem == CNT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tflite_img_reader.sv
// tb_tflite_img_reader: directed self-checking bench for tflite_img_reader.
// Buffer model returns the address as data, except 0x020 holds 0x11223344.
module tb_tflite_img_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] word_cnt;
  logic        busy;
  logic        done;
  logic [11:0] buf_adb;
  logic        buf_ceb;
  logic        buf_oce;
  logic [31:0] buf_dout = '0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  int checks   = 0;
  int failures = 0;

  tflite_img_reader dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .word_cnt(word_cnt),
    .busy(busy), .done(done),
    .buf_adb(buf_adb), .buf_ceb(buf_ceb), .buf_oce(buf_oce),
    .buf_dout(buf_dout),
    .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] buf_word(input logic [11:0] a);
    if (a == 12'h020) return 32'h11223344;
    return {20'h0, a};
  endfunction

  function automatic logic [31:0] exp_word(input logic [11:0] a);
    logic [31:0] w;
    w = buf_word(a);
`ifdef TFLITE_IMG_READER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  always @(posedge clk) begin
    if (buf_ceb) buf_dout <= buf_word(buf_adb);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ceb"}, buf_ceb, 0);
    chk({tag, "_adb"}, buf_adb, 0);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_last"}, m_last, 0);
    chk({tag, "_data"}, m_data, 0);
  endtask

  // start a transfer, then track issues, handshakes, stalls and done
  task automatic xfer(input logic [11:0] base, input logic [12:0] cnt,
                      input bit stall);
    int k, iss, lastc;
    bit fin, held, seen;
    logic [31:0] pd;
    logic pl;
    logic [11:0] a;
    k = 0; iss = 0; lastc = 0;
    fin = 0; held = 0; seen = 0;
    pd = '0; pl = 1'b0;
    start = 1'b1; base_addr = base; word_cnt = cnt; m_ready = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc < 400 && !fin; cyc++) begin
      if (buf_ceb) begin
        a = base + iss[11:0];
        chk("issue_addr", buf_adb, a);
        iss++;
      end
      chk("fifo_occ_le_4", dut.count <= 4, 1);
      m_ready = stall ? (cyc % 4 == 3 || cyc % 4 == 2) : 1'b1;
      if (m_valid && !seen) begin
        chk("first_valid_cycle", cyc, 3);
        seen = 1;
      end
      if (held) begin
        chk("stall_data", m_data, pd);
        chk("stall_last", m_last, pl);
      end
      if (m_valid && m_ready) begin
        a = base + k[11:0];
        chk("word_data", m_data, exp_word(a));
        chk("word_last", m_last, k == cnt - 1);
        k++;
        lastc = cyc;
      end
      held = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      if (done) begin
        fin = 1;
        chk("done_word_count", k, cnt);
        chk("done_latency", cyc, lastc + 1);
        chk("done_busy", busy, 1);
        chk("done_valid", m_valid, 0);
      end
      step();
    end
    if (!fin) chk("done_timeout", 0, 1);
    chk("issue_count", iss, cnt);
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0;
    word_cnt = '0; m_ready = 1'b0;
    step();
    step();
    chk_zero("reset");
    chk("oce_tied", buf_oce, 1);
    reset = 1'b0;
    step();

    xfer(12'h010, 13'd4, 1'b0);
    xfer(12'hFFE, 13'd4, 1'b0);
    xfer(12'h000, 13'd8, 1'b1);

    // zero-length transfer, plus a start while busy
    start = 1'b1; base_addr = 12'h005; word_cnt = 13'd0;
    step();
    word_cnt = 13'd5;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 1);
    chk("zero_ceb", buf_ceb, 0);
    chk("zero_valid", m_valid, 0);
    step();
    start = 1'b0;
    chk("zero_done_end", done, 0);
    chk("zero_busy_end", busy, 0);
    chk("ignored_ceb", buf_ceb, 0);
    step();
    chk("ignored_ceb2", buf_ceb, 0);
    chk("ignored_busy", busy, 0);
    chk("ignored_valid", m_valid, 0);

    // reset two words into a long transfer
    start = 1'b1; base_addr = 12'h040; word_cnt = 13'd16; m_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_valid", m_valid, 1);
    reset = 1'b1;
    #1;
    chk_zero("midreset");
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("after_reset_valid", m_valid, 0);
      chk("after_reset_busy", busy, 0);
    end
    xfer(12'h100, 13'd2, 1'b0);

    xfer(12'h020, 13'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
